// File: rtl/mvp_pkg.sv
// Shared types, widths and fixed-point helpers for the vertex matrix-vector path.
package mvp_pkg;

  localparam int WIDTH = 8;
  localparam int FRAC  = 7;

  // Truncated product keeps the integer bits of the full product (UQ2.7).
  localparam int PW = 2 * WIDTH - FRAC;
  // Row sum width: wide enough for the three terms once each product is limited.
  localparam int SW = WIDTH + 2;

  typedef logic [WIDTH-1:0] fx_t;
  typedef logic [PW-1:0]    prod_t;
  typedef logic [SW-1:0]    sum_t;

  // One row's worth of stage-1 state: two truncated products and the translation term.
  typedef struct packed {
    prod_t p0;
    prod_t p1;
    fx_t   tr;
  } row_s1_t;

  // Clamp a row sum to the output format; anything at or above 2^WIDTH saturates.
  function automatic fx_t fx_sat(input sum_t s);
    if (|s[SW-1:WIDTH]) begin
      return '1;
    end
    return s[WIDTH-1:0];
  endfunction

  // A single product at or above 2^WIDTH already forces saturation, so it is
  // limited to exactly 2^WIDTH before the add. The final clamped result is
  // unchanged and the three-term sum then always fits in SW bits.
  function automatic sum_t prod_lim(input prod_t p);
    if (p >= prod_t'(1 << WIDTH)) begin
      return sum_t'(1 << WIDTH);
    end
    return sum_t'(p);
  endfunction

endpackage

// File: rtl/mvp_fxmul.sv
// Unsigned WIDTH x WIDTH fixed-point multiply, floor-truncated by FRAC bits.
module mvp_fxmul
  import mvp_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [PW-1:0]    p_o
);

  logic [2*WIDTH-1:0] full;

  assign full = a_i * b_i;
  // Dropping the low FRAC bits is a floor for unsigned operands.
  assign p_o  = full[2*WIDTH-1:FRAC];

endmodule

// File: rtl/mvp_matvec.sv
// 2x4 MVP slice times homogeneous point [x, y, 0, 1], two-stage pipeline,
// saturating unsigned UQ1.7 outputs. One point accepted every clock.
module mvp_matvec
  import mvp_pkg::*;
(
  input  logic             clock,
  input  logic             io_aresetn,
  input  logic [WIDTH-1:0] io_vec4_0,
  input  logic [WIDTH-1:0] io_vec4_1,
  input  logic [WIDTH-1:0] io_mat4_0_0,
  input  logic [WIDTH-1:0] io_mat4_0_1,
  input  logic [WIDTH-1:0] io_mat4_0_2,
  input  logic [WIDTH-1:0] io_mat4_0_3,
  input  logic [WIDTH-1:0] io_mat4_1_0,
  input  logic [WIDTH-1:0] io_mat4_1_1,
  input  logic [WIDTH-1:0] io_mat4_1_2,
  input  logic [WIDTH-1:0] io_mat4_1_3,
  output logic [WIDTH-1:0] io_outVec4_0,
  output logic [WIDTH-1:0] io_outVec4_1
);

  // z coordinate of the homogeneous point; always zero for 2D input.
  localparam fx_t HOMO_Z = '0;

  fx_t     mat [2][4];
  prod_t   prod [2][2];
  row_s1_t s1_d [2];
  row_s1_t s1_q [2];
  sum_t    sum  [2];
  fx_t     out_d [2];
  fx_t     out_q [2];

  assign mat[0][0] = io_mat4_0_0;
  assign mat[0][1] = io_mat4_0_1;
  assign mat[0][2] = io_mat4_0_2;
  assign mat[0][3] = io_mat4_0_3;
  assign mat[1][0] = io_mat4_1_0;
  assign mat[1][1] = io_mat4_1_1;
  assign mat[1][2] = io_mat4_1_2;
  assign mat[1][3] = io_mat4_1_3;

  for (genvar r = 0; r < 2; r++) begin : g_row
    mvp_fxmul u_mul_x (
      .a_i (mat[r][0]),
      .b_i (io_vec4_0),
      .p_o (prod[r][0])
    );
    mvp_fxmul u_mul_y (
      .a_i (mat[r][1]),
      .b_i (io_vec4_1),
      .p_o (prod[r][1])
    );
  end

  // Stage-1 next state: products plus the w=1 translation column. The z column
  // is gated by z=0, so its contribution is identically zero and folds away.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      s1_d[r].p0 = prod[r][0];
      s1_d[r].p1 = prod[r][1];
      s1_d[r].tr = mat[r][3] | (mat[r][2] & HOMO_Z);
    end
  end

  // Stage-1 registers; reset clears them so no stale data survives a reset.
  always_ff @(posedge clock or negedge io_aresetn) begin
    if (!io_aresetn) begin
      for (int r = 0; r < 2; r++) begin
        s1_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 2; r++) begin
        s1_q[r] <= s1_d[r];
      end
    end
  end

  // Stage-2 next state: add the three terms per row and saturate.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      sum[r]   = prod_lim(s1_q[r].p0) + prod_lim(s1_q[r].p1) + sum_t'(s1_q[r].tr);
      out_d[r] = fx_sat(sum[r]);
    end
  end

  // Stage-2 output registers.
  always_ff @(posedge clock or negedge io_aresetn) begin
    if (!io_aresetn) begin
      for (int r = 0; r < 2; r++) begin
        out_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 2; r++) begin
        out_q[r] <= out_d[r];
      end
    end
  end

  assign io_outVec4_0 = out_q[0];
  assign io_outVec4_1 = out_q[1];

endmodule

// File: tb/tb_mvp_matvec.sv
// Directed bench for mvp_matvec: reset, arithmetic cases, saturation,
// truncation, streaming with a reference model, and mid-stream reset.
module tb_mvp_matvec;

  logic       clock = 1'b0;
  logic       io_aresetn;
  logic [7:0] v0, v1;
  logic [7:0] m [2][4];
  logic [7:0] o0, o1;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mvp_matvec dut (
    .clock        (clock),
    .io_aresetn   (io_aresetn),
    .io_vec4_0    (v0),
    .io_vec4_1    (v1),
    .io_mat4_0_0  (m[0][0]),
    .io_mat4_0_1  (m[0][1]),
    .io_mat4_0_2  (m[0][2]),
    .io_mat4_0_3  (m[0][3]),
    .io_mat4_1_0  (m[1][0]),
    .io_mat4_1_1  (m[1][1]),
    .io_mat4_1_2  (m[1][2]),
    .io_mat4_1_3  (m[1][3]),
    .io_outVec4_0 (o0),
    .io_outVec4_1 (o1)
  );

  function automatic logic [7:0] ref_row(input logic [7:0] x, input logic [7:0] y,
                                         input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] t);
    int s;
    s = (int'(a) * int'(x)) / 128 + (int'(b) * int'(y)) / 128 + int'(t);
    if (s > 255) s = 255;
    return s[7:0];
  endfunction

  task automatic set_row(input int r, input logic [7:0] c0, input logic [7:0] c1,
                         input logic [7:0] c2, input logic [7:0] c3);
    m[r][0] = c0;
    m[r][1] = c1;
    m[r][2] = c2;
    m[r][3] = c3;
  endtask

  task automatic set_all(input logic [7:0] val);
    v0 = val;
    v1 = val;
    set_row(0, val, val, val, val);
    set_row(1, val, val, val, val);
  endtask

  task automatic randomize_inputs();
    v0 = 8'($urandom);
    v1 = 8'($urandom);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = 8'($urandom);
  endtask

  task automatic test_reset();
    io_aresetn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      randomize_inputs();
      #1;
      checks++;
      if (o0 !== 8'h00 || o1 !== 8'h00) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: got %h/%h want 00/00", i, o0, o1);
      end
    end
    @(negedge clock);
    set_all(8'h00);
    io_aresetn = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (o0 !== 8'h00 || o1 !== 8'h00) begin
      failures++;
      $display("FAIL reset_release: got %h/%h want 00/00", o0, o1);
    end
  endtask

  task automatic test_uniform();
    set_all(8'h40);
    @(negedge clock);
    checks++;
    if (o0 !== 8'h00 || o1 !== 8'h00) begin
      failures++;
      $display("FAIL uniform_latency1: got %h/%h want 00/00", o0, o1);
    end
    @(negedge clock);
    checks++;
    if (o0 !== 8'h80 || o1 !== 8'h80) begin
      failures++;
      $display("FAIL uniform_half: got %h/%h want 80/80", o0, o1);
    end
  endtask

  task automatic test_mixed();
    v0 = 8'h40;
    v1 = 8'h60;
    set_row(0, 8'h80, 8'h40, 8'h20, 8'h10);
    set_row(1, 8'h80, 8'h40, 8'hE7, 8'h10);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (o0 !== 8'h80 || o1 !== 8'h80) begin
      failures++;
      $display("FAIL mixed_zcol: got %h/%h want 80/80", o0, o1);
    end
  endtask

  task automatic test_saturation();
    set_all(8'hFF);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (o0 !== 8'hFF || o1 !== 8'hFF) begin
      failures++;
      $display("FAIL sat_all_ff: got %h/%h want ff/ff", o0, o1);
    end
    v0 = 8'h00;
    v1 = 8'h00;
    set_row(0, 8'hFF, 8'hFF, 8'hFF, 8'h33);
    set_row(1, 8'hFF, 8'hFF, 8'hFF, 8'h33);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (o0 !== 8'h33 || o1 !== 8'h33) begin
      failures++;
      $display("FAIL translate_only: got %h/%h want 33/33", o0, o1);
    end
    // Row 0 sums to exactly 0x100 (clamps); row 1 sums to 0xFE (passes).
    v0 = 8'h80;
    v1 = 8'h80;
    set_row(0, 8'h80, 8'h80, 8'h00, 8'h00);
    set_row(1, 8'h80, 8'h7E, 8'h00, 8'h00);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (o0 !== 8'hFF || o1 !== 8'hFE) begin
      failures++;
      $display("FAIL sat_boundary: got %h/%h want ff/fe", o0, o1);
    end
  endtask

  task automatic test_truncation();
    v0 = 8'h01;
    v1 = 8'h00;
    set_row(0, 8'h01, 8'h00, 8'h00, 8'h00);
    set_row(1, 8'h01, 8'h00, 8'h00, 8'h00);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (o0 !== 8'h00 || o1 !== 8'h00) begin
      failures++;
      $display("FAIL trunc_floor: got %h/%h want 00/00", o0, o1);
    end
    v0 = 8'h80;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (o0 !== 8'h01 || o1 !== 8'h01) begin
      failures++;
      $display("FAIL trunc_one_lsb: got %h/%h want 01/01", o0, o1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp0 [20];
    logic [7:0] exp1 [20];
    for (int c = 0; c < 22; c++) begin
      @(negedge clock);
      if (c >= 2) begin
        checks++;
        if (o0 !== exp0[c-2] || o1 !== exp1[c-2]) begin
          failures++;
          $display("FAIL stream[%0d]: got %h/%h want %h/%h", c - 2, o0, o1, exp0[c-2], exp1[c-2]);
        end
      end
      if (c < 20) begin
        randomize_inputs();
        exp0[c] = ref_row(v0, v1, m[0][0], m[0][1], m[0][3]);
        exp1[c] = ref_row(v0, v1, m[1][0], m[1][1], m[1][3]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] e0, e1;
    set_all(8'h40);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (o0 !== 8'h80 || o1 !== 8'h80) begin
      failures++;
      $display("FAIL midrst_prefill: got %h/%h want 80/80", o0, o1);
    end
    #2;
    io_aresetn = 1'b0;
    #1;
    checks++;
    if (o0 !== 8'h00 || o1 !== 8'h00) begin
      failures++;
      $display("FAIL midrst_async_clear: got %h/%h want 00/00", o0, o1);
    end
    @(negedge clock);
    v0 = 8'h80;
    v1 = 8'h40;
    set_row(0, 8'h20, 8'h40, 8'h11, 8'h05);
    set_row(1, 8'h60, 8'h10, 8'h22, 8'h30);
    e0 = 8'h45; // 0x20 + 0x20 + 0x05
    e1 = 8'h98; // 0x60 + 0x08 + 0x30
    io_aresetn = 1'b1;
    @(negedge clock);
    checks++;
    if (o0 !== 8'h00 || o1 !== 8'h00) begin
      failures++;
      $display("FAIL midrst_no_stale: got %h/%h want 00/00", o0, o1);
    end
    @(negedge clock);
    checks++;
    if (o0 !== e0 || o1 !== e1) begin
      failures++;
      $display("FAIL midrst_first_result: got %h/%h want %h/%h", o0, o1, e0, e1);
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_mixed();
    test_saturation();
    test_truncation();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
